inst_fetch_unit: RTL and testbench

//   Fetch stage sitting directly upstream of InstMemory. Owns the program counter, drives the

---
 rtl/inst_fetch_unit.sv | 105 ++++++++++
 tb/tb_inst_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, reads InstMemory with zero wait states and buffers {pc, inst}
// pairs in a small FIFO toward decode. Redirects flush the buffer and may halt on misalignment.
//   state    | meaning
//   ST_FETCH | fetching sequentially, pushing into FIFO when room (or same-cycle pop)
//   ST_FAULT | halted on misaligned redirect target, no pushes, misaligned_out=1
module inst_fetch_unit #(
  parameter int unsigned              ADDR_WIDTH = 64,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
  parameter int unsigned              BUF_DEPTH  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic [DATA_WIDTH-1:0] imem_data_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic                  inst_valid_out,
  input  logic                  inst_ready_in,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  misaligned_out
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_buf_q   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] inst_buf_q [BUF_DEPTH];
  logic                  push, pop;

  assign imem_addr_out  = fetch_pc_q;
  assign inst_valid_out = (count_q != '0);
  assign misaligned_out = (state_q == ST_FAULT);
  assign inst_out       = inst_valid_out ? inst_buf_q[rd_ptr_q] : '0;
  assign pc_out         = inst_valid_out ? pc_buf_q[rd_ptr_q]   : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pop        = inst_valid_out & inst_ready_in;
    // A same-cycle pop frees the slot, so a full FIFO still streams one instruction per cycle.
    push       = (state_q == ST_FETCH) & ~redirect_valid_in &
                 ((count_q < CW'(BUF_DEPTH)) | pop);

    if (redirect_valid_in) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc_in;
      state_d    = (redirect_pc_in[1:0] == 2'b00) ? ST_FETCH : ST_FAULT;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observable while count is non-zero.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && push) begin
      pc_buf_q[wr_ptr_q]   <= fetch_pc_q;
      inst_buf_q[wr_ptr_q] <= imem_data_in;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: vector table for streaming/backpressure/redirect,
// hand sequences for FAULT, mid-stream reset and PC wrap (second instance, high RESET_PC).
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: RESET_PC = 0
  logic        rst_n_a, redir_a, ready_a;
  logic [63:0] redir_pc_a, addr_a, pc_a, addr_sh_a;
  logic [31:0] data_a, inst_a;
  logic        valid_a, mis_a;

  // DUT B: RESET_PC near the top of the address space
  logic        rst_n_b, ready_b;
  logic [63:0] addr_b, pc_b, addr_sh_b;
  logic [31:0] data_b, inst_b;
  logic        valid_b, mis_b;

  // Memory model: word at byte address a holds (a/4) + 0x100
  assign addr_sh_a = addr_a >> 2;
  assign addr_sh_b = addr_b >> 2;
  assign data_a    = addr_sh_a[31:0] + 32'h100;
  assign data_b    = addr_sh_b[31:0] + 32'h100;

  inst_fetch_unit #(.RESET_PC(64'h0)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n_a), .imem_addr_out(addr_a), .imem_data_in(data_a),
    .redirect_valid_in(redir_a), .redirect_pc_in(redir_pc_a), .inst_valid_out(valid_a),
    .inst_ready_in(ready_a), .inst_out(inst_a), .pc_out(pc_a), .misaligned_out(mis_a));

  inst_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n_b), .imem_addr_out(addr_b), .imem_data_in(data_b),
    .redirect_valid_in(1'b0), .redirect_pc_in(64'h0), .inst_valid_out(valid_b),
    .inst_ready_in(ready_b), .inst_out(inst_b), .pc_out(pc_b), .misaligned_out(mis_b));

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic check_a(input string tag, input logic ev, input logic [63:0] epc,
                         input logic [31:0] einst, input logic emis, input logic [63:0] eaddr);
    chk({tag, " valid"}, {63'b0, valid_a}, {63'b0, ev});
    chk({tag, " pc"},    pc_a, epc);
    chk({tag, " inst"},  {32'b0, inst_a}, {32'b0, einst});
    chk({tag, " mis"},   {63'b0, mis_a}, {63'b0, emis});
    chk({tag, " addr"},  addr_a, eaddr);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [63:0] rpc;
    logic        ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic        e_mis;
    logic [63:0] e_addr;
  } vec_t;

  vec_t vecs [19];

  initial begin
    // test 1: streaming, no bubbles
    vecs[0]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,   1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h0,   32'h100, 1'b0, 64'h4};
    vecs[2]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   32'h101, 1'b0, 64'h8};
    vecs[3]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   32'h102, 1'b0, 64'hC};
    vecs[4]  = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'hC,   32'h103, 1'b0, 64'h10};
    // test 2: backpressure saturates at 2, then drains in order
    vecs[5]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,   1'b0, 64'h0};
    vecs[6]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   32'h100, 1'b0, 64'h4};
    vecs[7]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   32'h100, 1'b0, 64'h8};
    vecs[8]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   32'h100, 1'b0, 64'h8};
    vecs[9]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   32'h100, 1'b0, 64'h8};
    vecs[10] = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   32'h100, 1'b0, 64'h8};
    vecs[11] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   32'h101, 1'b0, 64'hC};
    vecs[12] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   32'h102, 1'b0, 64'h10};
    // test 3: redirect while full discards buffered pc 0/4
    vecs[13] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,   1'b0, 64'h0};
    vecs[14] = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   32'h100, 1'b0, 64'h4};
    vecs[15] = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   32'h100, 1'b0, 64'h8};
    vecs[16] = '{1'b1, 1'b1, 64'h100, 1'b1, 1'b0, 64'h0,   32'h0,   1'b0, 64'h100};
    vecs[17] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h100, 32'h140, 1'b0, 64'h104};
    vecs[18] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h104, 32'h141, 1'b0, 64'h108};

    rst_n_a = 1'b0; redir_a = 1'b0; redir_pc_a = 64'h0; ready_a = 1'b1;
    rst_n_b = 1'b0; ready_b = 1'b1;

    for (int i = 0; i < 19; i++) begin
      rst_n_a    = vecs[i].rst_n;
      redir_a    = vecs[i].redir;
      redir_pc_a = vecs[i].rpc;
      ready_a    = vecs[i].ready;
      tick();
      check_a($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst,
              vecs[i].e_mis, vecs[i].e_addr);
    end

    // test 4: misaligned redirect holds in FAULT, retargets, recovers on aligned redirect
    redir_a = 1'b1; redir_pc_a = 64'h102; ready_a = 1'b1;
    tick();
    check_a("fault_enter", 1'b0, 64'h0, 32'h0, 1'b1, 64'h102);
    redir_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_a($sformatf("fault_hold%0d", i), 1'b0, 64'h0, 32'h0, 1'b1, 64'h102);
    end
    redir_a = 1'b1; redir_pc_a = 64'h203;
    tick();
    check_a("fault_retarget", 1'b0, 64'h0, 32'h0, 1'b1, 64'h203);
    redir_pc_a = 64'h200;
    tick();
    check_a("fault_exit", 1'b0, 64'h0, 32'h0, 1'b0, 64'h200);
    redir_a = 1'b0;
    tick();
    check_a("resume", 1'b1, 64'h200, 32'h180, 1'b0, 64'h204);

    // test 6: reset mid-stream with a full FIFO
    ready_a = 1'b0;
    tick();
    check_a("fill", 1'b1, 64'h200, 32'h180, 1'b0, 64'h208);
    rst_n_a = 1'b0; ready_a = 1'b1;
    tick();
    check_a("midrst", 1'b0, 64'h0, 32'h0, 1'b0, 64'h0);
    rst_n_a = 1'b1;
    tick();
    check_a("restart0", 1'b1, 64'h0, 32'h100, 1'b0, 64'h4);
    tick();
    check_a("restart1", 1'b1, 64'h4, 32'h101, 1'b0, 64'h8);

    // test 5: PC wrap from the top of the address space
    rst_n_b = 1'b0;
    tick();
    chk("wrap rst valid", {63'b0, valid_b}, 64'h0);
    chk("wrap rst addr", addr_b, 64'hFFFF_FFFF_FFFF_FFF8);
    rst_n_b = 1'b1;
    tick();
    chk("wrap0 pc", pc_b, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap0 inst", {32'b0, inst_b}, 64'h0000_00FE);
    chk("wrap0 addr", addr_b, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap1 pc", pc_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap1 inst", {32'b0, inst_b}, 64'h0000_00FF);
    chk("wrap1 addr", addr_b, 64'h0);
    tick();
    chk("wrap2 pc", pc_b, 64'h0);
    chk("wrap2 inst", {32'b0, inst_b}, 64'h100);
    chk("wrap2 valid", {63'b0, valid_b}, 64'h1);
    tick();
    chk("wrap3 pc", pc_b, 64'h4);
    chk("wrap3 inst", {32'b0, inst_b}, 64'h101);
    chk("wrap3 mis", {63'b0, mis_b}, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
